// File: rtl/reg_seq_pkg.sv
// reg_seq_pkg: opcodes and FSM encoding for the register access sequencer.
// Optional readback compare is enabled by defining REG_SEQ_READBACK_EN.
package reg_seq_pkg;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_PRESET = 2'b10;
  localparam logic [1:0] OP_NOP    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  function automatic logic is_pulse_op(input logic [1:0] op);
    return (op == OP_CLEAR) || (op == OP_PRESET);
  endfunction

endpackage

// File: rtl/reg_access_sequencer_arb.sv
// rr_arb2: two-way round-robin arbiter for the register sequencer.
// Pointer favours requester 0 after reset and flips past each winner.
module rr_arb2 (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant_idx,
  output logic       grant_valid
);

  logic ptr_q;
  logic ptr_d;

  // Lone requester wins; on contention the pointer decides
  always_comb begin
    grant_valid = |req;
    unique case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ptr_q;
      default: grant_idx = 1'b0;
    endcase
    ptr_d = advance ? ~grant_idx : ptr_q;
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (clr) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/reg_access_sequencer.sv
// reg_access_sequencer: shares a preset/clear D bank between two requesters.
// Define REG_SEQ_READBACK_EN to build the reg_q readback compare on err.
module reg_access_sequencer
  import reg_seq_pkg::*;
#(
  parameter int W         = 4,
  parameter int PULSE_CYC = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [1:0]   req,
  input  logic [1:0]   op0,
  input  logic [1:0]   op1,
  input  logic [W-1:0] data0,
  input  logic [W-1:0] data1,
  output logic [1:0]   ack,
  output logic         busy,
  output logic [W-1:0] reg_d,
  output logic         reg_en,
  output logic         reg_pre_n,
  output logic         reg_clr_n,
  input  logic [W-1:0] reg_q,
  output logic         err
);

  localparam int CW = $clog2(PULSE_CYC + 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           win_q, win_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   reg_d_q, reg_d_d;
  logic           en_q, en_d;
  logic           pre_n_q, pre_n_d;
  logic           clr_n_q, clr_n_d;
  logic [1:0]     ack_q, ack_d;
  logic           busy_q, busy_d;

  logic           gnt_idx;
  logic           gnt_valid;
  logic           advance;
  logic [1:0]     op_sel;
  logic [W-1:0]   data_sel;

  rr_arb2 u_arb (
    .clk        (clk),
    .clr        (clr),
    .req        (req),
    .advance    (advance),
    .grant_idx  (gnt_idx),
    .grant_valid(gnt_valid)
  );

  assign op_sel   = gnt_idx ? op1   : op0;
  assign data_sel = gnt_idx ? data1 : data0;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      win_q   <= 1'b0;
      op_q    <= OP_NOP;
      reg_d_q <= '0;
      en_q    <= 1'b0;
      pre_n_q <= 1'b1;
      clr_n_q <= 1'b1;
      ack_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      op_q    <= op_d;
      reg_d_q <= reg_d_d;
      en_q    <= en_d;
      pre_n_q <= pre_n_d;
      clr_n_q <= clr_n_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: grant in IDLE, count down in EXEC, one ACK cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    op_d    = op_q;
    reg_d_d = reg_d_q;
    advance = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          state_d = S_EXEC;
          win_d   = gnt_idx;
          op_d    = op_sel;
          reg_d_d = data_sel;
          advance = 1'b1;
          cnt_d   = is_pulse_op(op_sel) ? CW'(PULSE_CYC) : CW'(1);
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = S_ACK;
      end
      S_ACK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so strobes align with it
  always_comb begin
    en_d    = (state_d == S_EXEC) && (op_d == OP_LOAD);
    pre_n_d = !((state_d == S_EXEC) && (op_d == OP_PRESET));
    clr_n_d = !((state_d == S_EXEC) && (op_d == OP_CLEAR));
    busy_d  = (state_d != S_IDLE);
    ack_d   = 2'b00;
    if (state_d == S_ACK) ack_d = win_d ? 2'b10 : 2'b01;
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign reg_d     = reg_d_q;
  assign reg_en    = en_q;
  assign reg_pre_n = pre_n_q;
  assign reg_clr_n = clr_n_q;

`ifdef REG_SEQ_READBACK_EN
  logic [W-1:0] rb_exp;

  // Bank Q has settled by ACK, so err is decoded live alongside ack
  always_comb begin
    unique case (op_q)
      OP_CLEAR:  rb_exp = '0;
      OP_PRESET: rb_exp = '1;
      default:   rb_exp = reg_d_q;
    endcase
  end

  assign err = (state_q == S_ACK) && (op_q != OP_NOP) &&
               (reg_q != rb_exp);
`else
  logic unused_reg_q;
  assign unused_reg_q = ^reg_q;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_access_sequencer.sv
// tb_reg_access_sequencer: scoreboard bench with a transaction-level model
// of round-robin arbitration and a behavioural preset/clear bank.
module tb_reg_access_sequencer;

  localparam int W = 4;
  localparam int P = 2;
`ifdef REG_SEQ_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam logic [1:0] LD = 2'b00;
  localparam logic [1:0] CL = 2'b01;
  localparam logic [1:0] PR = 2'b10;
  localparam logic [1:0] NP = 2'b11;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] data;
  } cmd_t;

  typedef struct packed {
    logic         who;
    logic [1:0]   op;
    logic [W-1:0] data;
    logic [W-1:0] bank;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         clr;
  logic [1:0]   req;
  logic [1:0]   op0, op1;
  logic [W-1:0] data0, data1;
  logic [1:0]   ack;
  logic         busy;
  logic [W-1:0] reg_d;
  logic         reg_en, reg_pre_n, reg_clr_n;
  logic [W-1:0] reg_q;
  logic         err;

  logic [W-1:0] bank_q;
  logic         force_en;
  logic [W-1:0] force_val;

  int checks = 0;
  int errors = 0;

  cmd_t q0[$];
  cmd_t q1[$];
  exp_t sb[$];
  int   mptr = 0;
  logic [W-1:0] mbank = '0;

  reg_access_sequencer #(.W(W), .PULSE_CYC(P)) dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .op0      (op0),
    .op1      (op1),
    .data0    (data0),
    .data1    (data1),
    .ack      (ack),
    .busy     (busy),
    .reg_d    (reg_d),
    .reg_en   (reg_en),
    .reg_pre_n(reg_pre_n),
    .reg_clr_n(reg_clr_n),
    .reg_q    (reg_q),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reg_pre_n or negedge reg_clr_n)
    if (!reg_clr_n)     bank_q <= '0;
    else if (!reg_pre_n) bank_q <= '1;
    else if (reg_en)     bank_q <= reg_d;

  assign reg_q = force_en ? force_val : bank_q;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int en_c = 0, pre_c = 0, clr_c = 0, busy_c = 0;

  always @(negedge clk) begin
    exp_t e;
    if (clr) begin
      en_c = 0; pre_c = 0; clr_c = 0; busy_c = 0;
    end else begin
      chk("invariant", 32'((!reg_pre_n && !reg_clr_n) ||
          (reg_en && !(reg_pre_n && reg_clr_n))), 32'd0);
      if (busy) busy_c++;
      if (reg_en) en_c++;
      if (!reg_pre_n) pre_c++;
      if (!reg_clr_n) clr_c++;
      if (ack != 2'b00) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ack_who", 32'(ack), e.who ? 32'd2 : 32'd1);
          chk("reg_d", 32'(reg_d), 32'(e.data));
          chk("en_cycles", 32'(en_c), (e.op == LD) ? 32'd1 : 32'd0);
          chk("pre_cycles", 32'(pre_c), (e.op == PR) ? 32'(P) : 32'd0);
          chk("clr_cycles", 32'(clr_c), (e.op == CL) ? 32'(P) : 32'd0);
          chk("busy_cycles", 32'(busy_c),
              (e.op == CL || e.op == PR) ? 32'(P + 1) : 32'd2);
          chk("err", 32'(err), 32'(e.err));
          if (e.op != NP) chk("bank", 32'(bank_q), 32'(e.bank));
        end
        en_c = 0; pre_c = 0; clr_c = 0; busy_c = 0;
      end else begin
        chk("err_no_ack", 32'(err), 32'd0);
      end
    end
  end

  task automatic add(input int who, input logic [1:0] op,
                     input logic [W-1:0] d);
    cmd_t c;
    c.op = op;
    c.data = d;
    if (who == 0) q0.push_back(c);
    else          q1.push_back(c);
  endtask

  task automatic run_scn();
    int a, b, n0, n1, w, lim, cyc;
    cmd_t c;
    exp_t e;
    logic [W-1:0] tgt, seen;
    a = 0; b = 0; cyc = 0;
    n0 = q0.size(); n1 = q1.size();
    while (a < n0 || b < n1) begin
      if (a < n0 && b < n1) w = mptr;
      else                  w = (a < n0) ? 0 : 1;
      mptr = 1 - w;
      if (w == 0) begin c = q0[a]; a++; end
      else        begin c = q1[b]; b++; end
      case (c.op)
        LD:      tgt = c.data;
        CL:      tgt = '0;
        PR:      tgt = '1;
        default: tgt = mbank;
      endcase
      mbank = tgt;
      seen = force_en ? force_val : tgt;
      e.who = (w == 1);
      e.op = c.op;
      e.data = c.data;
      e.bank = tgt;
      e.err = RB && (c.op != NP) && (seen != tgt);
      sb.push_back(e);
    end
    lim = 10 * (n0 + n1) + 20;
    @(posedge clk); #2;
    req[0] = (q0.size() != 0);
    req[1] = (q1.size() != 0);
    if (q0.size() != 0) begin op0 = q0[0].op; data0 = q0[0].data; end
    if (q1.size() != 0) begin op1 = q1[0].op; data1 = q1[0].data; end
    while ((q0.size() != 0 || q1.size() != 0) && cyc < lim) begin
      @(posedge clk); #2;
      cyc++;
      if (ack[0] && q0.size() != 0) begin
        void'(q0.pop_front());
        if (q0.size() != 0) begin op0 = q0[0].op; data0 = q0[0].data; end
        else req[0] = 1'b0;
      end
      if (ack[1] && q1.size() != 0) begin
        void'(q1.pop_front());
        if (q1.size() != 0) begin op1 = q1[0].op; data1 = q1[0].data; end
        else req[1] = 1'b0;
      end
    end
    if (cyc >= lim) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d cycles without all acks, required < %0d",
               cyc, lim);
      req = 2'b00;
      q0.delete();
      q1.delete();
      sb.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int n0, n1;
    clr = 1'b1;
    req = 2'b00;
    op0 = NP; op1 = NP;
    data0 = '0; data1 = '0;
    force_en = 1'b0;
    force_val = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_pre_n", 32'(reg_pre_n), 32'd1);
    chk("rst_clr_n", 32'(reg_clr_n), 32'd1);
    chk("rst_en", 32'(reg_en), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_reg_d", 32'(reg_d), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    clr = 1'b0;
    mptr = 0;

    add(0, LD, 4'hA);
    run_scn();
    add(1, CL, 4'h3);
    run_scn();
    add(0, PR, 4'h1); add(0, PR, 4'h2);
    add(1, CL, 4'h7); add(1, CL, 4'h8);
    run_scn();

    force_en = 1'b1;
    force_val = 4'h4;
    add(0, LD, 4'h5);
    run_scn();
    force_en = 1'b0;

    @(posedge clk); #2;
    req = 2'b01; op0 = PR; data0 = 4'h9;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("midop_pre_low", 32'(reg_pre_n), 32'd0);
    clr = 1'b1;
    req = 2'b00;
    @(posedge clk); #2;
    chk("midop_pre_n", 32'(reg_pre_n), 32'd1);
    chk("midop_busy", 32'(busy), 32'd0);
    chk("midop_ack", 32'(ack), 32'd0);
    chk("midop_reg_d", 32'(reg_d), 32'd0);
    clr = 1'b0;
    mptr = 0;
    mbank = '1;
    repeat (3) @(posedge clk);

    add(0, LD, 4'hC); add(1, LD, 4'h3);
    run_scn();

    for (int s = 0; s < 30; s++) begin
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 == 0 && n1 == 0) n0 = 1;
      for (int k = 0; k < n0; k++)
        add(0, 2'($urandom_range(0, 3)), W'($urandom_range(0, 15)));
      for (int k = 0; k < n1; k++)
        add(1, 2'($urandom_range(0, 3)), W'($urandom_range(0, 15)));
      run_scn();
    end

    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
